mem_lsu: RTL

Load/store unit sitting directly upstream of `mem_data` in the single-cycle RISC16 datapath. It accepts one load or store request at a time from the core over a valid/ready handshake and drives `mem_data`'s write-enable, address and write-data. It absorbs the memory's read latency (asynchronous or registered read) and returns a held response to the core. It rejects out-of-range addresses without touching memory and counts those errors.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/sat_counter.sv | 30 +++
 rtl/mem_lsu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and width constants for the RISC16 load/store unit and the
// core-side bus decode that must agree with it.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam int LSU_ERR_CNT_W    = 8;
    localparam int LSU_DEF_WORD_LEN = 16;
    localparam int LSU_DEF_ADDR_LEN = 10;
    localparam int LSU_MAX_RD_LAT   = 1;

    // The memory address must fit in a core word and the read latency must match a mem_data mode.
    function automatic bit lsu_cfg_ok(input int word_len, input int addr_len, input int rd_lat);
        return (addr_len >= 32'sd1) && (addr_len <= word_len) &&
               (rd_lat >= 32'sd0) && (rd_lat <= LSU_MAX_RD_LAT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low reset; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int p_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_inc,
    output logic [p_WIDTH-1:0] o_cnt
);

    localparam logic [p_WIDTH-1:0] cnt_max_c = {p_WIDTH{1'b1}};
    localparam logic [p_WIDTH-1:0] cnt_one_c = p_WIDTH'(1);

    logic [p_WIDTH-1:0] cnt_r;

    // Count register: increment on request unless already saturated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {p_WIDTH{1'b0}};
        end else if (i_inc && (cnt_r != cnt_max_c)) begin
            cnt_r <= cnt_r + cnt_one_c;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_cnt = cnt_r;

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of mem_data: one request at a time, absorbs the
// memory read latency, holds the response, rejects out-of-range addresses.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int p_WORD_LEN = LSU_DEF_WORD_LEN,
    parameter int p_ADDR_LEN = LSU_DEF_ADDR_LEN,
    parameter int p_RD_LAT   = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [p_WORD_LEN-1:0]    i_req_addr,
    input  logic [p_WORD_LEN-1:0]    i_req_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [p_WORD_LEN-1:0]    o_rsp_rdata,
    output logic                     o_rsp_err,
    output logic                     o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0]    o_mem_addr,
    output logic [p_WORD_LEN-1:0]    o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0]    i_mem_rd_data,
    output logic [LSU_ERR_CNT_W-1:0] o_err_cnt
);

    generate
        if (!lsu_cfg_ok(p_WORD_LEN, p_ADDR_LEN, p_RD_LAT)) begin : g_bad_cfg
            $error("mem_lsu: p_RD_LAT must be 0 or 1 and p_ADDR_LEN must not exceed p_WORD_LEN");
        end
    endgenerate

    localparam logic                  rd_sync_c = (p_RD_LAT == 32'sd1);
    localparam logic [p_WORD_LEN-1:0] zero_word_c = {p_WORD_LEN{1'b0}};

    lsu_state_e              state_r;
    lsu_state_e              next_state_s;
    logic                    accept_s;
    logic                    oor_s;
    logic [p_ADDR_LEN-1:0]   addr_r;
    logic [p_WORD_LEN-1:0]   rdata_r;
    logic                    err_r;

    // Any bit above the memory address range marks the request out of range.
    assign oor_s    = ((i_req_addr >> p_ADDR_LEN) != zero_word_c);
    assign accept_s = i_req_valid && (state_r == IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: only in-range loads on a registered memory detour via WAIT.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    next_state_s = IDLE;
                end else if (i_req_we || oor_s || !rd_sync_c) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            WAIT: next_state_s = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Request latch and held response; cleared when the core consumes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_r  <= {p_ADDR_LEN{1'b0}};
            rdata_r <= zero_word_c;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r <= i_req_addr[p_ADDR_LEN-1:0];
                        err_r  <= oor_s;
                        if (i_req_we || oor_s || rd_sync_c) begin
                            rdata_r <= zero_word_c;
                        end else begin
                            rdata_r <= i_mem_rd_data;
                        end
                    end
                end
                WAIT: begin
                    rdata_r <= i_mem_rd_data;
                    err_r   <= 1'b0;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rdata_r <= zero_word_c;
                        err_r   <= 1'b0;
                    end
                end
                default: begin
                    rdata_r <= zero_word_c;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .p_WIDTH (LSU_ERR_CNT_W)
    ) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (accept_s && oor_s),
        .o_cnt   (o_err_cnt)
    );

    assign o_req_ready   = (state_r == IDLE);
    assign o_rsp_valid   = (state_r == RESP);
    assign o_rsp_rdata   = rdata_r;
    assign o_rsp_err     = err_r;
    assign o_mem_addr    = (state_r == IDLE) ? i_req_addr[p_ADDR_LEN-1:0] : addr_r;
    assign o_mem_wr_data = i_req_wdata;
    // Gating with reset keeps a store still waiting for its accept edge from ever landing.
    assign o_mem_wr_en   = accept_s && i_req_we && !oor_s && i_rst_n;

endmodule
